shift_issue_stage: RTL and testbench
====================================

// Module: shift_issue_stage
// PURPOSE
//  Registered issue stage directly upstream of the combinational shifter (in, Shift_Amount, Alufun).
//  Decodes RV32I shift instructions (SLL/SRL/SRA, SLLI/SRLI/SRAI), selects the operand and shift amount,
//  and holds them in a 2-entry skid buffer with valid/ready handshakes and flush.
//  Outputs sh_data/sh_amt/sh_fun wire straight to the shifter; sh_rd and sh_illegal travel with the result.
// PARAMETERS
//  XLEN     32  data width of rs1/rs2/sh_data
//  SHAMT_W  5   shift-amount width; must equal log2(XLEN)
// PORTS
//  clk         in   1        single clock, rising edge
//  rst         in   1        asynchronous, active-high reset
//  flush       in   1        synchronous kill of all held and incoming entries
//  in_valid    in   1        upstream offers an instruction
//  in_ready    out  1        stage can accept this cycle
//  opcode      in   7        inst[6:0]
//  funct3      in   3        inst[14:12]
//  funct7      in   7        inst[31:25]
//  rs1_data    in   XLEN     value to shift
//  rs2_data    in   XLEN     R-type shift amount source (low SHAMT_W bits)
//  imm_shamt   in   SHAMT_W  I-type shamt, inst[24:20]
//  rd          in   5        destination register
//  out_valid   out  1        head entry valid
//  out_ready   in   1        downstream consumes head this cycle
//  sh_data     out  XLEN     to shifter 'in'
//  sh_amt      out  SHAMT_W  to shifter 'Shift_Amount'
//  sh_fun      out  2        to shifter 'Alufun': 00 SRL, 01 SLL, 10 SRA, 11 none
//  sh_rd       out  5        rd of head entry
//  sh_illegal  out  1        head entry is not a legal shift
//  occ         out  2        entries held: 0, 1 or 2
// BEHAVIOUR
//  - Decode (combinational, on the input side, before registering):
//    opcode 0110011 -> amt = rs2_data[SHAMT_W-1:0]; opcode 0010011 -> amt = imm_shamt.
//    funct3 001 & funct7 0000000 -> SLL (01); funct3 101 & funct7 0000000 -> SRL (00);
//    funct3 101 & funct7 0100000 -> SRA (10). Anything else -> sh_fun 11, illegal 1, amt 0.
//  - Storage: head register (drives outputs) plus skid register. occ = head_v + skid_v.
//  - in_ready = !skid_v (registered state; no combinational path from out_ready).
//  - Accept = in_valid & in_ready. Pop = out_valid & out_ready.
//  - Latency: an accept into an empty stage gives out_valid=1 on the next cycle.
//  - Per cycle:
//    accept, no pop, head empty -> entry to head.
//    accept, no pop, head full -> entry to skid; in_ready=0 next cycle.
//    accept and pop, skid empty -> entry replaces head; occ stays 1.
//    pop, skid full -> skid moves to head; skid clears; in_ready=1 next cycle
//      (no accept is possible, because in_ready=0).
//    pop only, skid empty -> head clears.
//  - Outputs hold stable while out_valid & !out_ready.
//  - FIFO order is preserved.
//  - flush (wins over everything): next cycle occ=0, out_valid=0, in_ready=1.
//    An input accepted in the same cycle is discarded. Data outputs return to reset values.
//  - Reset (async assert, mid-transfer allowed):
//    out_valid=0, occ=0, in_ready=1, sh_data=0, sh_amt=0, sh_fun=11, sh_rd=0, sh_illegal=0.
//    Held entries are lost.
//  - While out_valid=0: sh_fun=11, so the shifter outputs 0.
// TESTING
//  1. After reset, check in_ready=1, out_valid=0, sh_fun=11, occ=0.
//     Then send one SRAI (0010011/101/0100000), rs1=0xFFFF_FF00, shamt=4, out_ready=1
//     -> next cycle: out_valid=1, sh_data=0xFFFF_FF00, sh_amt=4, sh_fun=10.
//  2. SLL R-type, rs2=0x0000_0025 -> sh_amt=5 (only the low 5 bits are used), sh_fun=01.
//  3. Hold out_ready=0 and offer 3 back-to-back SRLs with rd=1,2,3
//     -> occ goes 1 then 2; in_ready=0 after the 2nd accept; the 3rd is held upstream.
//     Release out_ready -> rd 1,2,3 come out in order, with no loss and no duplicates.
//  4. Illegal funct7 0100000 with funct3 001 -> sh_illegal=1, sh_fun=11, sh_amt=0.
//  5. occ=2, then assert flush together with in_valid
//     -> next cycle occ=0, out_valid=0, in_ready=1; the flushed rd never appears at the output.
//  6. Assert rst asynchronously mid-cycle while occ=2
//     -> outputs go to reset values immediately. After release, a new SLLI passes with 1-cycle latency.

Source files
------------

// File: rtl/shift_issue_stage.sv
// Issue stage ahead of the combinational shifter: decodes RV32I shifts and holds
// up to two decoded entries in a head/skid buffer with valid/ready and flush.
module shift_issue_stage #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic [6:0]         funct7,
  input  logic [XLEN-1:0]    rs1_data,
  input  logic [XLEN-1:0]    rs2_data,
  input  logic [SHAMT_W-1:0] imm_shamt,
  input  logic [4:0]         rd,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    sh_data,
  output logic [SHAMT_W-1:0] sh_amt,
  output logic [1:0]         sh_fun,
  output logic [4:0]         sh_rd,
  output logic               sh_illegal,
  output logic [1:0]         occ
);

  typedef struct packed {
    logic [XLEN-1:0]    data;
    logic [SHAMT_W-1:0] amt;
    logic [1:0]         fun;
    logic [4:0]         rd;
    logic               illegal;
  } entry_t;

  localparam logic [1:0] FUN_SRL  = 2'b00;
  localparam logic [1:0] FUN_SLL  = 2'b01;
  localparam logic [1:0] FUN_SRA  = 2'b10;
  localparam logic [1:0] FUN_NONE = 2'b11;

  entry_t head, skid, dec, empty_entry;
  logic   head_v, skid_v;
  logic   accept, pop;
  logic   is_r, is_i;
  logic   unused_rs2_hi;

  assign unused_rs2_hi = ^rs2_data[XLEN-1:SHAMT_W];

  always_comb begin
    empty_entry         = '0;
    empty_entry.fun     = FUN_NONE;
  end

  always_comb begin
    is_r        = (opcode == 7'b0110011);
    is_i        = (opcode == 7'b0010011);
    dec         = '0;
    dec.data    = rs1_data;
    dec.rd      = rd;
    dec.fun     = FUN_NONE;
    dec.illegal = 1'b1;
    if (is_r || is_i) begin
      if (funct3 == 3'b001 && funct7 == 7'b0000000) begin
        dec.fun     = FUN_SLL;
        dec.illegal = 1'b0;
      end else if (funct3 == 3'b101 && funct7 == 7'b0000000) begin
        dec.fun     = FUN_SRL;
        dec.illegal = 1'b0;
      end else if (funct3 == 3'b101 && funct7 == 7'b0100000) begin
        dec.fun     = FUN_SRA;
        dec.illegal = 1'b0;
      end
    end
    if (!dec.illegal) begin
      dec.amt = is_r ? rs2_data[SHAMT_W-1:0] : imm_shamt;
    end
  end

  assign in_ready = !skid_v;
  assign accept   = in_valid && in_ready;
  assign pop      = head_v && out_ready;

  // An empty head is reloaded with reset values so sh_fun reads NONE whenever out_valid is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_v <= 1'b0;
      skid_v <= 1'b0;
      head   <= empty_entry;
      skid   <= empty_entry;
    end else if (flush) begin
      head_v <= 1'b0;
      skid_v <= 1'b0;
      head   <= empty_entry;
      skid   <= empty_entry;
    end else if (pop) begin
      if (skid_v) begin
        head   <= skid;
        skid   <= empty_entry;
        skid_v <= 1'b0;
      end else if (accept) begin
        head   <= dec;
      end else begin
        head   <= empty_entry;
        head_v <= 1'b0;
      end
    end else if (accept) begin
      if (!head_v) begin
        head   <= dec;
        head_v <= 1'b1;
      end else begin
        skid   <= dec;
        skid_v <= 1'b1;
      end
    end
  end

  assign out_valid  = head_v;
  assign sh_data    = head.data;
  assign sh_amt     = head.amt;
  assign sh_fun     = head.fun;
  assign sh_rd      = head.rd;
  assign sh_illegal = head.illegal;
  assign occ        = 2'(head_v) + 2'(skid_v);

endmodule

// File: tb/tb_shift_issue_stage.sv
// Directed bench for shift_issue_stage: decode vector table plus buffering,
// flush and asynchronous reset sequences.
module tb_shift_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [4:0]  imm_shamt;
  logic [4:0]  rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sh_data;
  logic [4:0]  sh_amt;
  logic [1:0]  sh_fun;
  logic [4:0]  sh_rd;
  logic        sh_illegal;
  logic [1:0]  occ;

  int checks = 0;
  int errors = 0;

  shift_issue_stage #(.XLEN(32), .SHAMT_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm_shamt(imm_shamt), .rd(rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .sh_data(sh_data), .sh_amt(sh_amt), .sh_fun(sh_fun), .sh_rd(sh_rd),
    .sh_illegal(sh_illegal), .occ(occ)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  imm;
    logic [4:0]  rd;
    logic [4:0]  exp_amt;
    logic [1:0]  exp_fun;
    logic        exp_ill;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] r1, input logic [31:0] r2, input logic [4:0] im,
                       input logic [4:0] d);
    opcode = op; funct3 = f3; funct7 = f7;
    rs1_data = r1; rs2_data = r2; imm_shamt = im; rd = d;
    in_valid = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_empty(input string tag);
    check({tag, "_occ"}, 32'(occ), 0);
    check({tag, "_out_valid"}, 32'(out_valid), 0);
    check({tag, "_in_ready"}, 32'(in_ready), 1);
    check({tag, "_sh_fun"}, 32'(sh_fun), 3);
    check({tag, "_sh_data"}, sh_data, 0);
    check({tag, "_sh_rd"}, 32'(sh_rd), 0);
  endtask

  initial begin
    logic [4:0] got_rd[$];
    logic       acc;

    //            opcode      f3      f7          rs1           rs2           imm  rd  amt  fun    ill
    vecs[0] = '{7'b0010011, 3'b101, 7'b0100000, 32'hFFFF_FF00, 32'h0,        5'd4,  5'd5, 5'd4,  2'b10, 1'b0};
    vecs[1] = '{7'b0110011, 3'b001, 7'b0000000, 32'h1234_5678, 32'h0000_0025, 5'd7,  5'd6, 5'd5,  2'b01, 1'b0};
    vecs[2] = '{7'b0110011, 3'b101, 7'b0000000, 32'h8000_0001, 32'h0000_001F, 5'd2,  5'd7, 5'd31, 2'b00, 1'b0};
    vecs[3] = '{7'b0110011, 3'b101, 7'b0100000, 32'hDEAD_BEEF, 32'hFFFF_FFE3, 5'd9,  5'd8, 5'd3,  2'b10, 1'b0};
    vecs[4] = '{7'b0010011, 3'b001, 7'b0000000, 32'h0000_0001, 32'hFFFF_FFFF, 5'd0,  5'd9, 5'd0,  2'b01, 1'b0};
    vecs[5] = '{7'b0010011, 3'b101, 7'b0000000, 32'hA5A5_A5A5, 32'h0000_0003, 5'd31, 5'd31, 5'd31, 2'b00, 1'b0};
    vecs[6] = '{7'b0110011, 3'b001, 7'b0100000, 32'h0F0F_0F0F, 32'h0000_0004, 5'd4,  5'd10, 5'd0,  2'b11, 1'b1};
    vecs[7] = '{7'b0000011, 3'b101, 7'b0000000, 32'h1111_1111, 32'h0000_0004, 5'd4,  5'd11, 5'd0,  2'b11, 1'b1};
    vecs[8] = '{7'b0110011, 3'b000, 7'b0000000, 32'h2222_2222, 32'h0000_0004, 5'd4,  5'd12, 5'd0,  2'b11, 1'b1};
    vecs[9] = '{7'b0010011, 3'b101, 7'b0000001, 32'h3333_3333, 32'h0000_0004, 5'd4,  5'd13, 5'd0,  2'b11, 1'b1};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    opcode = '0; funct3 = '0; funct7 = '0; rs1_data = '0; rs2_data = '0; imm_shamt = '0; rd = '0;
    #12;
    check_empty("reset");
    @(negedge clk);
    rst = 1'b0;
    step();
    check_empty("post_reset");

    // Decode table: each entry goes into an empty stage and must appear one cycle later.
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].opcode, vecs[i].funct3, vecs[i].funct7, vecs[i].rs1, vecs[i].rs2,
            vecs[i].imm, vecs[i].rd);
      step();
      in_valid = 1'b0;
      check($sformatf("v%0d_out_valid", i), 32'(out_valid), 1);
      check($sformatf("v%0d_sh_data", i), sh_data, vecs[i].rs1);
      check($sformatf("v%0d_sh_amt", i), 32'(sh_amt), 32'(vecs[i].exp_amt));
      check($sformatf("v%0d_sh_fun", i), 32'(sh_fun), 32'(vecs[i].exp_fun));
      check($sformatf("v%0d_sh_illegal", i), 32'(sh_illegal), 32'(vecs[i].exp_ill));
      check($sformatf("v%0d_sh_rd", i), 32'(sh_rd), 32'(vecs[i].rd));
      check($sformatf("v%0d_occ", i), 32'(occ), 1);
      step();
      check($sformatf("v%0d_drained_valid", i), 32'(out_valid), 0);
      check($sformatf("v%0d_drained_fun", i), 32'(sh_fun), 3);
    end

    // Back-pressure: three SRLs with the output stalled, then drain in order.
    out_ready = 1'b0;
    drive(7'b0110011, 3'b101, 7'b0000000, 32'h100, 32'h1, 5'd0, 5'd1);
    step();
    check("bp1_occ", 32'(occ), 1);
    check("bp1_in_ready", 32'(in_ready), 1);
    drive(7'b0110011, 3'b101, 7'b0000000, 32'h200, 32'h2, 5'd0, 5'd2);
    step();
    check("bp2_occ", 32'(occ), 2);
    check("bp2_in_ready", 32'(in_ready), 0);
    drive(7'b0110011, 3'b101, 7'b0000000, 32'h300, 32'h3, 5'd0, 5'd3);
    step();
    check("bp3_occ", 32'(occ), 2);
    check("bp3_hold_rd", 32'(sh_rd), 1);
    check("bp3_hold_data", sh_data, 32'h100);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && got_rd.size() < 3; c++) begin
      if (out_valid) got_rd.push_back(sh_rd);
      acc = in_valid && in_ready;
      step();
      if (acc) in_valid = 1'b0;
    end
    check("bp_count", 32'(got_rd.size()), 3);
    for (int k = 0; k < 3; k++) begin
      if (k < got_rd.size()) check($sformatf("bp_order%0d", k), 32'(got_rd[k]), 32'(k + 1));
    end
    in_valid = 1'b0;
    step();
    check("bp_drained_occ", 32'(occ), 0);

    // Flush with a full buffer and an offered input.
    out_ready = 1'b0;
    drive(7'b0010011, 3'b001, 7'b0000000, 32'hA, 32'h0, 5'd1, 5'd10);
    step();
    drive(7'b0010011, 3'b001, 7'b0000000, 32'hB, 32'h0, 5'd1, 5'd11);
    step();
    check("fl_full_occ", 32'(occ), 2);
    drive(7'b0010011, 3'b001, 7'b0000000, 32'hC, 32'h0, 5'd1, 5'd12);
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check_empty("flush2");
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("fl_quiet%0d", c), 32'(out_valid), 0);
    end

    // Flush with one held entry while a new one is accepted in the same cycle.
    out_ready = 1'b0;
    drive(7'b0010011, 3'b101, 7'b0000000, 32'hD, 32'h0, 5'd2, 5'd20);
    step();
    drive(7'b0010011, 3'b101, 7'b0000000, 32'hE, 32'h0, 5'd2, 5'd21);
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check_empty("flush1");

    // Asynchronous reset in mid-cycle with two entries held.
    drive(7'b0110011, 3'b001, 7'b0000000, 32'h55, 32'h1, 5'd0, 5'd25);
    step();
    drive(7'b0110011, 3'b001, 7'b0000000, 32'h66, 32'h1, 5'd0, 5'd26);
    step();
    in_valid = 1'b0;
    check("ar_full_occ", 32'(occ), 2);
    #2;
    rst = 1'b1;
    #1;
    check_empty("async_reset");
    check("ar_sh_amt", 32'(sh_amt), 0);
    check("ar_sh_illegal", 32'(sh_illegal), 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    out_ready = 1'b1;
    drive(7'b0010011, 3'b001, 7'b0000000, 32'h0000_00F0, 32'h0, 5'd6, 5'd30);
    step();
    in_valid = 1'b0;
    check("ar_slli_valid", 32'(out_valid), 1);
    check("ar_slli_fun", 32'(sh_fun), 1);
    check("ar_slli_amt", 32'(sh_amt), 6);
    check("ar_slli_data", sh_data, 32'h0000_00F0);
    check("ar_slli_rd", 32'(sh_rd), 30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
